line_buffer_taps: RTL and testbench

Parametrised multi-row line buffer for the camera pixel pipeline. It accepts one pixel per valid cycle in raster order. For every accepted pixel it presents a vertical column of taps: the current pixel plus the pixels at the same column in the previous NUM_TAPS rows. It feeds 3x3 (or larger) convolution and filter stages. Row length is programmable at runtime up to a compile-time maximum, and storage is circular RAM rather than a shift chain.

---
 rtl/line_buf_pkg.sv | 29 ++
 rtl/line_ram.sv | 23 ++
 rtl/line_buffer_taps.sv | 109 ++++++++++
 tb/tb_line_buffer_taps.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared types and sizing helpers for the line buffer
package line_buf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int DEFAULT_MAX_ROW_SIZE = 1280;
  localparam int DEFAULT_PIXEL_SIZE   = 12;
  localparam int DEFAULT_NUM_TAPS     = 2;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a field holding 0..n inclusive.
  function automatic int len_width(input int n);
    return cnt_width(n + 1);
  endfunction

  // Zero or oversize lengths fall back to the full RAM depth.
  function automatic int clamp_len(input int len, input int max_len);
    return (len == 0 || len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port row RAM, synchronous write with read-before-write data
module line_ram #(
  parameter int DEPTH = 1280,
  parameter int WIDTH = 12,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read returns the pre-write contents so the next bank can capture it in the same cycle.
  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/line_buffer_taps.sv
// rtl/line_buffer_taps.sv - multi-row line buffer presenting a vertical column of taps
// Optional LINE_BUFFER_ZERO_FILL_EN masks history rows not yet filled in the current frame.
module line_buffer_taps
  import line_buf_pkg::*;
#(
  parameter int MAX_ROW_SIZE = DEFAULT_MAX_ROW_SIZE,
  parameter int PIXEL_SIZE   = DEFAULT_PIXEL_SIZE,
  parameter int NUM_TAPS     = DEFAULT_NUM_TAPS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [$clog2(MAX_ROW_SIZE+1)-1:0]    row_len,
  input  logic                                 in_valid,
  input  logic                                 sof,
  input  logic [PIXEL_SIZE-1:0]                pixel,
  output logic                                 out_valid,
  output logic [(NUM_TAPS+1)*PIXEL_SIZE-1:0]   taps,
  output logic                                 out_eol,
  output logic                                 taps_full
);

  localparam int LEN_W = $clog2(MAX_ROW_SIZE+1);
  localparam int COL_W = cnt_width(MAX_ROW_SIZE);
  localparam int RF_W  = cnt_width(NUM_TAPS + 1);

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [RF_W-1:0]   rows_filled;
  logic [LEN_W-1:0]  len_q;

  logic              accept;
  logic [COL_W-1:0]  eff_col;
  logic [RF_W-1:0]   eff_rf;
  logic [LEN_W-1:0]  eff_len;
  logic              at_eol;
  logic [RF_W-1:0]   next_rf;
  logic [(NUM_TAPS+1)*PIXEL_SIZE-1:0] taps_d;

  logic [PIXEL_SIZE-1:0] wr_data [NUM_TAPS];
  logic [PIXEL_SIZE-1:0] rd_data [NUM_TAPS];

  // A start of frame overrides the running pointers for the pixel it arrives with.
  assign accept  = in_valid && (state != IDLE || sof);
  assign eff_col = sof ? '0 : col;
  assign eff_rf  = sof ? '0 : rows_filled;
  assign eff_len = sof ? LEN_W'(clamp_len(int'(row_len), MAX_ROW_SIZE)) : len_q;
  assign at_eol  = (LEN_W'(eff_col) == eff_len - LEN_W'(1));

  always_comb begin
    next_rf = eff_rf;
    if (at_eol && eff_rf != RF_W'(NUM_TAPS)) next_rf = eff_rf + RF_W'(1);
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_bank
    if (k == 0) begin : g_head
      assign wr_data[k] = pixel;
    end else begin : g_cascade
      assign wr_data[k] = rd_data[k-1];
    end
    line_ram #(
      .DEPTH (MAX_ROW_SIZE),
      .WIDTH (PIXEL_SIZE),
      .AW    (COL_W)
    ) u_ram (
      .clk     (clk),
      .we      (accept),
      .addr    (eff_col),
      .wr_data (wr_data[k]),
      .rd_data (rd_data[k])
    );
  end

  always_comb begin
    taps_d = '0;
    taps_d[PIXEL_SIZE-1:0] = pixel;
    for (int k = 1; k <= NUM_TAPS; k++) begin
`ifdef LINE_BUFFER_ZERO_FILL_EN
      if (RF_W'(k) <= eff_rf) taps_d[k*PIXEL_SIZE +: PIXEL_SIZE] = rd_data[k-1];
`else
      taps_d[k*PIXEL_SIZE +: PIXEL_SIZE] = rd_data[k-1];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      rows_filled <= '0;
      len_q       <= LEN_W'(MAX_ROW_SIZE);
      out_valid   <= 1'b0;
      out_eol     <= 1'b0;
      taps_full   <= 1'b0;
      taps        <= '0;
    end else begin
      out_valid <= accept;
      out_eol   <= accept && at_eol;
      taps_full <= accept && (eff_rf == RF_W'(NUM_TAPS));
      if (accept) begin
        taps        <= taps_d;
        col         <= at_eol ? '0 : eff_col + COL_W'(1);
        rows_filled <= next_rf;
        len_q       <= eff_len;
        state       <= (next_rf == RF_W'(NUM_TAPS)) ? STREAM : FILL;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_taps.sv
// tb/tb_line_buffer_taps.sv - randomized and directed bench for line_buffer_taps against a frame-history model
module tb_line_buffer_taps;

  localparam int MAXR = 8;
  localparam int PW   = 12;
  localparam int NT   = 2;
  localparam int TW   = (NT+1)*PW;

  logic          clk;
  logic          rst_n;
  logic [3:0]    row_len;
  logic          in_valid;
  logic          sof;
  logic [PW-1:0] pixel;
  logic          out_valid;
  logic [TW-1:0] taps;
  logic          out_eol;
  logic          taps_full;

  line_buffer_taps #(.MAX_ROW_SIZE(MAXR), .PIXEL_SIZE(PW), .NUM_TAPS(NT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_len   (row_len),
    .in_valid  (in_valid),
    .sof       (sof),
    .pixel     (pixel),
    .out_valid (out_valid),
    .taps      (taps),
    .out_eol   (out_eol),
    .taps_full (taps_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: the pixels of the current frame in arrival order, plus its clamped length.
  bit            in_frame = 1'b0;
  int            frame_len = MAXR;
  int            frame_pix[$];
  logic [TW-1:0] exp_taps = '0;
  logic [TW-1:0] mask = '1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic step(input bit v, input bit s, input int p, input int rl);
    bit acc;
    int idx, col, rows, rlv;
    bit e_eol, e_full;
    rlv = rl & 15;
    in_valid = v;
    sof      = s;
    pixel    = PW'(p);
    row_len  = 4'(rlv);
    acc = v && (in_frame || s);
    e_eol = 1'b0;
    e_full = 1'b0;
    if (acc) begin
      if (s) begin
        in_frame  = 1'b1;
        frame_len = (rlv == 0 || rlv > MAXR) ? MAXR : rlv;
        frame_pix.delete();
      end
      idx = frame_pix.size();
      frame_pix.push_back(p & 'hfff);
      col  = idx % frame_len;
      rows = idx / frame_len;
      if (rows > NT) rows = NT;
      e_eol  = (col == frame_len - 1);
      e_full = (rows == NT);
      exp_taps = '0;
      mask     = '0;
      for (int k = 0; k <= NT; k++) begin
        if (k <= rows) begin
          exp_taps[k*PW +: PW] = PW'(frame_pix[idx - k*frame_len]);
          mask[k*PW +: PW]     = '1;
        end else begin
`ifdef LINE_BUFFER_ZERO_FILL_EN
          mask[k*PW +: PW] = '1;
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, acc);
    if (acc) begin
      check("out_eol", out_eol, e_eol);
      check("taps_full", taps_full, e_full);
    end
    check("taps", taps & mask, exp_taps & mask);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    row_len  = '0;
    in_valid = 1'b0;
    sof      = 1'b0;
    pixel    = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_taps_full", taps_full, 0);
    check("rst_taps", taps, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pixels without sof while idle are ignored.
    step(1, 0, 11, 4);
    step(1, 0, 12, 4);

    // Continuous stream, row_len 4, pixels 1..12.
    for (int i = 1; i <= 12; i++) step(1, i == 1, i, 4);

    // Same stream with gaps; gap cycles carry junk, including sof without valid.
    for (int i = 1; i <= 12; i++) begin
      step(1, i == 1, i, 4);
      step(0, $urandom_range(0, 1), $urandom_range(0, 4095), $urandom_range(0, 15));
    end

    // Mid-frame sof with a shorter row.
    for (int i = 1; i <= 6; i++) step(1, i == 1, 50 + i, 4);
    for (int i = 0; i <= 6; i++) step(1, i == 0, 100 + i, 3);

    // Length clamp: zero and oversize both behave as the full depth.
    for (int i = 0; i < 20; i++) step(1, i == 0, 300 + i, 0);
    for (int i = 0; i < 20; i++) step(1, i == 0, 400 + i, 15);

    // sof lands on the pixel that would have wrapped the row.
    for (int i = 0; i < 7; i++) step(1, i == 0, 200 + i, 4);
    step(1, 1, 207, 4);
    for (int i = 8; i < 14; i++) step(1, 0, 200 + i, 4);

    // Random traffic with random lengths and occasional restarts.
    step(1, 1, $urandom_range(0, 4095), $urandom_range(1, 8));
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 4095), $urandom_range(0, 15));

    // Asynchronous reset between edges while output is valid.
    step(1, 1, 77, 4);
    step(1, 0, 78, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_taps", taps, 0);
    check("async_rst_taps_full", taps_full, 0);
    in_frame = 1'b0;
    exp_taps = '0;
    mask     = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 500 + i, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
